// File: rtl/ring_cam.sv
// ring_cam: circular-write content-addressable memory with single-cycle registered search.
// Define RING_CAM_BYPASS_EN to forward a same-cycle write into the search result.
module ring_cam #(
  parameter  int DATA_W = 24,
  parameter  int DEPTH  = 64,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              search_en,
  input  logic [DATA_W-1:0] search_data,
  output logic              match_valid,
  output logic              match_hit,
  output logic [IDX_W-1:0]  match_index,
  output logic [IDX_W:0]    count,
  output logic              full
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              full_q, full_d;
  logic              match_valid_q, match_valid_d;
  logic              match_hit_q, match_hit_d;
  logic [IDX_W-1:0]  match_index_q, match_index_d;

  logic              do_write_s;
  logic [DEPTH-1:0]  eq_s;
  logic              hit_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic              bypass_s;
  logic [IDX_W-1:0]  slot_v;

  assign do_write_s = wr_en & ~flush;

  // Per-slot compare against pre-write contents; invalid slots never match.
  always_comb begin
    eq_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      eq_s[i] = valid_q[i] & (mem_q[i] == search_data);
    end
  end

  // Walk slots oldest-to-youngest starting at wr_ptr so the youngest match wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {IDX_W{1'b0}};
    slot_v    = {IDX_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      slot_v    = wr_ptr_q + IDX_W'(k);
      hit_idx_s = eq_s[slot_v] ? slot_v : hit_idx_s;
      hit_s     = hit_s | eq_s[slot_v];
    end
  end

  // Same-cycle write forwarding, only in the bypass build.
  always_comb begin
`ifdef RING_CAM_BYPASS_EN
    bypass_s = do_write_s & search_en & (search_data == wr_data);
`else
    bypass_s = 1'b0;
`endif
  end

  // Next-state for valid bits, write pointer, occupancy and search result.
  always_comb begin
    valid_d       = valid_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    match_valid_d = search_en;
    match_hit_d   = 1'b0;
    match_index_d = {IDX_W{1'b0}};

    if (flush) begin
      valid_d  = {DEPTH{1'b0}};
      wr_ptr_d = {IDX_W{1'b0}};
      count_d  = {(IDX_W+1){1'b0}};
    end else if (wr_en) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + IDX_W'(1);
      count_d           = (count_q == FULL_CNT) ? count_q : count_q + (IDX_W+1)'(1);
    end else begin
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end

    if (!search_en) begin
      match_hit_d   = 1'b0;
      match_index_d = {IDX_W{1'b0}};
    end else if (bypass_s) begin
      match_hit_d   = 1'b1;
      match_index_d = wr_ptr_q;
    end else if (hit_s) begin
      match_hit_d   = 1'b1;
      match_index_d = hit_idx_s;
    end else begin
      match_hit_d   = 1'b0;
      match_index_d = {IDX_W{1'b0}};
    end

    full_d = (count_d == FULL_CNT);
  end

  // Control and result registers; reset discards any in-flight search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= {DEPTH{1'b0}};
      wr_ptr_q      <= {IDX_W{1'b0}};
      count_q       <= {(IDX_W+1){1'b0}};
      full_q        <= 1'b0;
      match_valid_q <= 1'b0;
      match_hit_q   <= 1'b0;
      match_index_q <= {IDX_W{1'b0}};
    end else begin
      valid_q       <= valid_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      match_valid_q <= match_valid_d;
      match_hit_q   <= match_hit_d;
      match_index_q <= match_index_d;
    end
  end

  // Data words carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign match_valid = match_valid_q;
  assign match_hit   = match_hit_q;
  assign match_index = match_index_q;
  assign count       = count_q;
  assign full        = full_q;

endmodule

// File: tb/tb_ring_cam.sv
// Randomized bench for ring_cam against a queue-based model of write history.
module tb_ring_cam;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = $clog2(DEPTH);
`ifdef RING_CAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              flush = 1'b0;
  logic              search_en = 1'b0;
  logic [DATA_W-1:0] search_data = '0;
  logic              match_valid, match_hit;
  logic [IDX_W-1:0]  match_index;
  logic [IDX_W:0]    count;
  logic              full;

  int n_cmp = 0;
  int n_err = 0;

  // Model: every live write as (data, slot), oldest first.
  logic [DATA_W-1:0] m_data[$];
  int                m_slot[$];
  int                m_next = 0;

  ring_cam #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .search_en(search_en), .search_data(search_data),
    .match_valid(match_valid), .match_hit(match_hit), .match_index(match_index),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_data.delete();
    m_slot.delete();
    m_next = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; flush = 1'b0; search_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(match_valid), 32'd0);
    check_eq("rst_hit",   32'(match_hit),   32'd0);
    check_eq("rst_index", 32'(match_index), 32'd0);
    check_eq("rst_count", 32'(count),       32'd0);
    check_eq("rst_full",  32'(full),        32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // One clock: drive, predict from the model, advance, compare.
  task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic fl,
                      input logic se, input logic [DATA_W-1:0] sd);
    logic e_hit;
    int   e_idx;
    int   e_cnt;
    wr_en = we; wr_data = wd; flush = fl; search_en = se; search_data = sd;
    e_hit = 1'b0;
    e_idx = 0;
    if (se) begin
      for (int i = m_data.size() - 1; i >= 0; i--) begin
        if (m_data[i] == sd) begin
          e_hit = 1'b1;
          e_idx = m_slot[i];
          break;
        end
      end
      if (BYP && we && !fl && (wd == sd)) begin
        e_hit = 1'b1;
        e_idx = m_next;
      end
    end
    if (fl) begin
      model_clear();
    end else if (we) begin
      m_data.push_back(wd);
      m_slot.push_back(m_next);
      if (m_data.size() > DEPTH) begin
        void'(m_data.pop_front());
        void'(m_slot.pop_front());
      end
      m_next = (m_next + 1) % DEPTH;
    end
    e_cnt = m_data.size();
    @(posedge clk);
    #1;
    check_eq("valid", 32'(match_valid), 32'(se));
    check_eq("hit",   32'(match_hit),   32'(e_hit));
    check_eq("index", 32'(match_index), 32'(e_idx));
    check_eq("count", 32'(count),       32'(e_cnt));
    check_eq("full",  32'(full),        32'(e_cnt == DEPTH));
  endtask

  initial begin
    logic [DATA_W-1:0] wd, sd;
    do_reset();

    // Three writes then search the middle one.
    for (int i = 1; i <= 3; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 24'h000002);
    check_eq("d035_index", 32'(match_index), 32'd1);
    check_eq("d035_count", 32'(count), 32'd3);

    // Empty CAM never matches, even on zero data.
    do_reset();
    step(1'b0, '0, 1'b0, 1'b1, 24'h000000);
    check_eq("d036_hit", 32'(match_hit), 32'd0);

    // Wrap: 65 writes overwrite slot 0.
    for (int i = 0; i <= 64; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 24'd0);
    check_eq("d037_hit0", 32'(match_hit), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1, 24'd64);
    check_eq("d037_hit64", 32'(match_hit), 32'd1);
    check_eq("d037_idx64", 32'(match_index), 32'd0);
    check_eq("d037_full", 32'(full), 32'd1);

    // Duplicate key: youngest slot reported.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, (i == 2 || i == 9) ? 24'hABCDEF : DATA_W'(i), 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 24'hABCDEF);
    check_eq("d038_index", 32'(match_index), 32'd9);

    // Same-cycle write and search of a new key into slot 5.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(i + 16), 1'b0, 1'b0, '0);
    step(1'b1, 24'h123456, 1'b0, 1'b1, 24'h123456);
    check_eq("d039_hit", 32'(match_hit), 32'(BYP));
    check_eq("d039_index", 32'(match_index), BYP ? 32'd5 : 32'd0);

    // Flush with write and search in the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(24'h0A0 + i), 1'b0, 1'b0, '0);
    step(1'b1, 24'h777777, 1'b1, 1'b1, 24'h0A0);
    check_eq("d040_hit", 32'(match_hit), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1, 24'h0A0);
    check_eq("d040_after", 32'(match_hit), 32'd0);
    step(1'b1, 24'h555555, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 24'h555555);
    check_eq("d040_slot0", 32'(match_index), 32'd0);

    // Search in flight when reset asserts is discarded.
    step(1'b0, '0, 1'b0, 1'b1, 24'h555555);
    rst = 1'b1;
    search_en = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(match_valid), 32'd0);
    do_reset();
    @(posedge clk);
    #1;
    check_eq("post_rst_valid", 32'(match_valid), 32'd0);

    // Randomized traffic over a small key pool to force hits, wraps and duplicates.
    for (int n = 0; n < 3000; n++) begin
      wd = ($urandom_range(0, 7) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 40));
      sd = ($urandom_range(0, 3) == 0) ? wd :
           (($urandom_range(0, 7) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 40)));
      step($urandom_range(0, 9) < 6, wd, $urandom_range(0, 249) == 0,
           $urandom_range(0, 9) < 7, sd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
